// File: rtl/pwm_capture_if.sv
// Measurement bundle for pwm_capture: raw PWM line in, registered duty/period results out.
interface pwm_capture_if #(
    parameter int unsigned WIDTH = 8
);
    logic             pwm_in;
    logic [WIDTH:0]   duty;
    logic [WIDTH:0]   period;
    logic             valid;
    logic             stuck;
    logic             level;

    modport master (
        output pwm_in,
        input  duty, period, valid, stuck, level
    );

    modport slave (
        input  pwm_in,
        output duty, period, valid, stuck, level
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: synchronises an asynchronous PWM line and reports high time and
// period (in clk cycles) per rising-edge-to-rising-edge period, with a stuck-line timeout.
module pwm_capture #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    pwm_capture_if.slave  bus
);
    localparam int unsigned   CW  = WIDTH + 1;
    localparam logic [CW-1:0] MAX = {CW{1'b1}};

    typedef enum logic {
        SEEK = 1'b0,
        MEAS = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          s3_q, s3_d;
    logic [CW-1:0] per_q, per_d;
    logic [CW-1:0] hi_q, hi_d;
    logic [CW-1:0] duty_q, duty_d;
    logic [CW-1:0] period_q, period_d;
    logic          valid_q, valid_d;
    logic          stuck_q, stuck_d;

    logic          rise_c;
    logic          at_max_c;
    logic [CW-1:0] per_inc_c;
    logic [CW-1:0] hi_inc_c;

    assign rise_c    = s2_q & ~s3_q;
    assign at_max_c  = (per_q == MAX);
    assign per_inc_c = at_max_c ? MAX : per_q + CW'(1);
    assign hi_inc_c  = (hi_q == MAX) ? MAX : hi_q + CW'(s2_q);

    // State, synchroniser and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SEEK;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            per_q    <= '0;
            hi_q     <= '0;
            duty_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            per_q    <= per_d;
            hi_q     <= hi_d;
            duty_q   <= duty_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
        end
    end

    // Next-state and measurement update; a rise always beats the timeout
    always_comb begin
        state_d  = state_q;
        s1_d     = bus.pwm_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        per_d    = per_q;
        hi_d     = hi_q;
        duty_d   = duty_q;
        period_d = period_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;

        if (rise_c) begin
            // The first rise only opens a period; the one before it was partial
            if (state_q == MEAS) begin
                duty_d   = hi_q;
                period_d = per_q;
                valid_d  = 1'b1;
            end else begin
                stuck_d  = 1'b0;
            end
            state_d = MEAS;
            per_d   = CW'(1);
            hi_d    = CW'(1);
        end else if (at_max_c) begin
            valid_d  = 1'b1;
            stuck_d  = 1'b1;
            period_d = '0;
            duty_d   = s2_q ? MAX : '0;
            per_d    = '0;
            hi_d     = '0;
            state_d  = SEEK;
        end else begin
            per_d = per_inc_c;
            hi_d  = (state_q == MEAS) ? hi_inc_c : '0;
        end
    end

    assign bus.duty   = duty_q;
    assign bus.period = period_q;
    assign bus.valid  = valid_q;
    assign bus.stuck  = stuck_q;
    assign bus.level  = s2_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: time-stamp based reference model checked every
// cycle, table-driven waveform vectors, and hand-written timeout/reset sequences.
module tb_pwm_capture;
    localparam int unsigned WIDTH = 8;
    localparam int          MAXV  = (1 << (WIDTH + 1)) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pwm_capture_if #(.WIDTH(WIDTH)) bus ();

    pwm_capture #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: line history plus time stamps of the last rise / timeout
    bit samp[$];
    int e;
    bit m_meas;
    int m_anchor;
    int x_duty, x_period;
    bit x_valid, x_stuck, x_level;

    // Section statistics from the DUT's own valid pulses
    int n_ok, n_stk, first_v;

    typedef struct {
        int per;
        int hi;
        int reps;
        int x_duty;
        int x_period;
        bit x_stuck;
    } vec_t;

    vec_t tbl[7];

    function automatic bit lvl(int n);
        if (n >= 3) return samp[n-2];
        return 1'b0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic model_reset();
        samp.delete();
        samp.push_back(1'b0);
        e        = 0;
        m_meas   = 1'b0;
        m_anchor = 0;
        x_duty   = 0;
        x_period = 0;
        x_valid  = 1'b0;
        x_stuck  = 1'b0;
        x_level  = 1'b0;
    endtask

    task automatic model_edge(input bit v);
        bit rise;
        int deadline;
        int s;
        e++;
        samp.push_back(v);
        rise     = lvl(e) && !lvl(e - 1);
        deadline = m_meas ? m_anchor + MAXV : m_anchor + MAXV + 1;
        x_valid  = 1'b0;
        if (rise) begin
            if (m_meas) begin
                s = 0;
                for (int k = m_anchor; k < e; k++) s += int'(lvl(k));
                x_valid  = 1'b1;
                x_period = e - m_anchor;
                x_duty   = s;
            end else begin
                x_stuck = 1'b0;
            end
            m_meas   = 1'b1;
            m_anchor = e;
        end else if (e == deadline) begin
            x_valid  = 1'b1;
            x_stuck  = 1'b1;
            x_period = 0;
            x_duty   = lvl(e) ? MAXV : 0;
            m_meas   = 1'b0;
            m_anchor = e;
        end
        x_level = lvl(e + 1);
    endtask

    function automatic int pack(bit v, bit st, bit lv, int d, int p);
        return 32'({v, st, lv, 9'(d), 9'(p)});
    endfunction

    task automatic clear_section();
        n_ok    = 0;
        n_stk   = 0;
        first_v = -1;
    endtask

    task automatic step(input bit v);
        @(negedge clk);
        bus.pwm_in = v;
        @(posedge clk);
        model_edge(v);
        #1;
        check("cycle", pack(bus.valid, bus.stuck, bus.level, int'(bus.duty), int'(bus.period)),
              pack(x_valid, x_stuck, x_level, x_duty, x_period));
        if (bus.valid) begin
            if (first_v < 0) first_v = e;
            if (bus.stuck) n_stk++;
            else           n_ok++;
        end
    endtask

    task automatic run_wave(input int per, input int hi, input int reps);
        for (int r = 0; r < reps; r++)
            for (int c = 0; c < per; c++)
                step(c < hi);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        bus.pwm_in = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        clear_section();
    endtask

    initial begin
        tbl[0] = '{256, 64, 3, 64, 256, 1'b0};
        tbl[1] = '{2,   1,  6, 1,  2,   1'b0};
        tbl[2] = '{100, 30, 3, 30, 100, 1'b0};
        tbl[3] = '{511, 64, 3, 64, 511, 1'b0};
        tbl[4] = '{7,   3,  4, 3,  7,   1'b0};
        tbl[5] = '{10,  9,  4, 9,  10,  1'b0};
        tbl[6] = '{300, 1,  3, 1,  300, 1'b0};

        bus.pwm_in = 1'b0;
        model_reset();
        do_reset();
        check("reset_outputs", pack(bus.valid, bus.stuck, bus.level, int'(bus.duty), int'(bus.period)), 0);

        // 256/64: first rise silent, second rise reports
        run_wave(256, 64, 1);
        check("first_rise_no_valid", n_ok + n_stk, 0);
        run_wave(256, 64, 1);
        check("second_rise_valid", n_ok, 1);
        check("second_rise_duty", int'(bus.duty), 64);
        check("second_rise_period", int'(bus.period), 256);

        // Table-driven waveforms; a trailing high forces the last period to report
        for (int i = 0; i < 7; i++) begin
            clear_section();
            run_wave(tbl[i].per, tbl[i].hi, tbl[i].reps);
            repeat (3) step(1'b1);
            check($sformatf("tbl%0d_duty", i), int'(bus.duty), tbl[i].x_duty);
            check($sformatf("tbl%0d_period", i), int'(bus.period), tbl[i].x_period);
            check($sformatf("tbl%0d_stuck", i), int'(bus.stuck), int'(tbl[i].x_stuck));
        end

        // Line held low from reset: heartbeat every MAX+1 cycles
        do_reset();
        repeat (1030) step(1'b0);
        check("low_timeouts", n_stk, 2);
        check("low_first_valid_edge", first_v, 512);
        check("low_duty", int'(bus.duty), 0);
        check("low_period", int'(bus.period), 0);
        check("low_stuck", int'(bus.stuck), 1);

        // Line held high, then a 100/30 waveform recovers
        do_reset();
        repeat (600) step(1'b1);
        check("high_timeouts", n_stk, 1);
        check("high_duty", int'(bus.duty), MAXV);
        check("high_stuck", int'(bus.stuck), 1);
        clear_section();
        run_wave(100, 30, 2);
        check("recover_no_valid", n_ok + n_stk, 0);
        check("recover_stuck_cleared", int'(bus.stuck), 0);
        run_wave(100, 30, 1);
        check("recover_valid", n_ok, 1);
        check("recover_duty", int'(bus.duty), 30);
        check("recover_period", int'(bus.period), 100);

        // Period 512 always times out before the next rise
        do_reset();
        run_wave(512, 64, 2);
        repeat (4) step(1'b0);
        check("p512_measurements", n_ok, 0);
        check("p512_timeouts", n_stk, 2);

        // Asynchronous reset in the middle of a period
        do_reset();
        run_wave(256, 64, 2);
        for (int c = 0; c < 100; c++) step(c < 64);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_outputs", pack(bus.valid, bus.stuck, bus.level, int'(bus.duty), int'(bus.period)), 0);
        bus.pwm_in = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        clear_section();
        run_wave(256, 64, 1);
        check("post_reset_no_valid", n_ok + n_stk, 0);
        run_wave(256, 64, 1);
        check("post_reset_valid", n_ok, 1);
        check("post_reset_duty", int'(bus.duty), 64);
        check("post_reset_period", int'(bus.period), 256);

        // Randomised waveforms, noise and static stretches against the model
        for (int i = 0; i < 15; i++) begin
            int per;
            int hi;
            per = int'($urandom_range(520, 2));
            hi  = int'($urandom_range(per - 1, 1));
            run_wave(per, hi, int'($urandom_range(3, 2)));
        end
        repeat (600) step(1'($urandom_range(1, 0)));
        repeat (1100) step(1'b1);
        repeat (1100) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
